// File: rtl/idex_alu_stage.sv
// -----------------------------------------------------------------------------
// idex_alu_stage
//
// Execute stage of the 5-stage MIPS pipeline. It holds the ID/EX pipeline
// register, forwards results from later stages, selects the second ALU
// operand, and computes the EX-stage result, flags and destination register.
//
// Ports
//   clk, resetn          : pipeline clock (rising edge), async active-low reset
//   stallE, flushE       : hazard-unit hold / bubble requests for ID/EX
//   alucontrolD ... rdD  : decoded D-stage controls, operands and specifiers
//   forwardaE, forwardbE : operand sources (00/11 reg, 01 resultW, 10 aluoutM)
//   aluoutM, resultW     : forwarded values from the MEM and WB stages
//   aluoutE, zeroE       : ALU result and its zero flag
//   overflowE            : signed overflow of add/sub (informational only)
//   writedataE           : forwarded B operand ahead of the immediate mux
//   writeregE            : destination register (rd or rt)
//   rsE, rtE             : registered source specifiers for the hazard unit
//   regwriteE, memtoregE, memwriteE : registered control bits
// -----------------------------------------------------------------------------
module idex_alu_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stallE,
  input  logic             flushE,
  input  logic [2:0]       alucontrolD,
  input  logic             alusrcD,
  input  logic             regdstD,
  input  logic             regwriteD,
  input  logic             memtoregD,
  input  logic             memwriteD,
  input  logic [WIDTH-1:0] rd1D,
  input  logic [WIDTH-1:0] rd2D,
  input  logic [WIDTH-1:0] signimmD,
  input  logic [REGW-1:0]  rsD,
  input  logic [REGW-1:0]  rtD,
  input  logic [REGW-1:0]  rdD,
  input  logic [1:0]       forwardaE,
  input  logic [1:0]       forwardbE,
  input  logic [WIDTH-1:0] aluoutM,
  input  logic [WIDTH-1:0] resultW,
  output logic [WIDTH-1:0] aluoutE,
  output logic [WIDTH-1:0] writedataE,
  output logic [REGW-1:0]  writeregE,
  output logic [REGW-1:0]  rsE,
  output logic [REGW-1:0]  rtE,
  output logic             regwriteE,
  output logic             memtoregE,
  output logic             memwriteE,
  output logic             zeroE,
  output logic             overflowE
);

  // ALU operation codes as produced by the decode-stage ALU decoder.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluOpT;

  // All ID/EX fields in one record so flush, stall and reset act on every
  // field uniformly. An all-zero record is a harmless bubble (AND, no writes).
  typedef struct packed {
    logic [2:0]       aluControl;
    logic             aluSrc;
    logic             regDst;
    logic             regWrite;
    logic             memToReg;
    logic             memWrite;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] signImm;
    logic [REGW-1:0]  rs;
    logic [REGW-1:0]  rt;
    logic [REGW-1:0]  rd;
  } idexT;

  idexT idex_d;
  idexT idex_q;

  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] fwdB;
  logic [WIDTH-1:0] sumR;
  logic [WIDTH-1:0] diffR;
  logic             sltR;
  logic [WIDTH-1:0] aluR;
  logic             ovfR;

  // Next ID/EX contents: flush beats stall, so a simultaneous request
  // still inserts a bubble.
  always_comb begin
    idex_d            = idex_q;
    if (flushE) begin
      idex_d = '0;
    end else if (!stallE) begin
      idex_d.aluControl = alucontrolD;
      idex_d.aluSrc     = alusrcD;
      idex_d.regDst     = regdstD;
      idex_d.regWrite   = regwriteD;
      idex_d.memToReg   = memtoregD;
      idex_d.memWrite   = memwriteD;
      idex_d.rd1        = rd1D;
      idex_d.rd2        = rd2D;
      idex_d.signImm    = signimmD;
      idex_d.rs         = rsD;
      idex_d.rt         = rtD;
      idex_d.rd         = rdD;
    end
  end

  // ID/EX register; reset drops any in-flight instruction immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // Forwarding muxes; code 11 is unused by the hazard unit and falls back
  // to the register value.
  always_comb begin
    srcA = idex_q.rd1;
    case (forwardaE)
      2'b01:   srcA = resultW;
      2'b10:   srcA = aluoutM;
      default: srcA = idex_q.rd1;
    endcase
    fwdB = idex_q.rd2;
    case (forwardbE)
      2'b01:   fwdB = resultW;
      2'b10:   fwdB = aluoutM;
      default: fwdB = idex_q.rd2;
    endcase
  end

  assign srcB  = idex_q.aluSrc ? idex_q.signImm : fwdB;
  assign sumR  = srcA + srcB;
  assign diffR = srcA - srcB;

  // Signed less-than that stays correct when the subtraction overflows:
  // with differing signs the negative operand is the smaller one.
  assign sltR = (srcA[WIDTH-1] != srcB[WIDTH-1]) ? srcA[WIDTH-1] : diffR[WIDTH-1];

  // ALU result and overflow; unused codes yield zero.
  always_comb begin
    aluR = '0;
    ovfR = 1'b0;
    case (aluOpT'(idex_q.aluControl))
      ALU_ADD: begin
        aluR = sumR;
        ovfR = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sumR[WIDTH-1] != srcA[WIDTH-1]);
      end
      ALU_SUB: begin
        aluR = diffR;
        ovfR = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diffR[WIDTH-1] != srcA[WIDTH-1]);
      end
      ALU_AND: aluR = srcA & srcB;
      ALU_OR:  aluR = srcA | srcB;
      ALU_SLT: aluR = {{(WIDTH-1){1'b0}}, sltR};
      default: aluR = '0;
    endcase
  end

  assign aluoutE    = aluR;
  assign overflowE  = ovfR;
  assign zeroE      = (aluR == '0);
  assign writedataE = fwdB;
  assign writeregE  = idex_q.regDst ? idex_q.rd : idex_q.rt;
  assign rsE        = idex_q.rs;
  assign rtE        = idex_q.rt;
  assign regwriteE  = idex_q.regWrite;
  assign memtoregE  = idex_q.memToReg;
  assign memwriteE  = idex_q.memWrite;

endmodule

// File: tb/tb_idex_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_idex_alu_stage
//
// Directed bench for idex_alu_stage: reset, add/sub/slt with flags,
// forwarding, stall/flush and the R-type store path, each with
// hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_idex_alu_stage;

  logic        clk;
  logic        resetn;
  logic        stallE;
  logic        flushE;
  logic [2:0]  alucontrolD;
  logic        alusrcD;
  logic        regdstD;
  logic        regwriteD;
  logic        memtoregD;
  logic        memwriteD;
  logic [31:0] rd1D;
  logic [31:0] rd2D;
  logic [31:0] signimmD;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [4:0]  rdD;
  logic [1:0]  forwardaE;
  logic [1:0]  forwardbE;
  logic [31:0] aluoutM;
  logic [31:0] resultW;
  logic [31:0] aluoutE;
  logic [31:0] writedataE;
  logic [4:0]  writeregE;
  logic [4:0]  rsE;
  logic [4:0]  rtE;
  logic        regwriteE;
  logic        memtoregE;
  logic        memwriteE;
  logic        zeroE;
  logic        overflowE;

  int checks;
  int failures;

  idex_alu_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .stallE     (stallE),
    .flushE     (flushE),
    .alucontrolD(alucontrolD),
    .alusrcD    (alusrcD),
    .regdstD    (regdstD),
    .regwriteD  (regwriteD),
    .memtoregD  (memtoregD),
    .memwriteD  (memwriteD),
    .rd1D       (rd1D),
    .rd2D       (rd2D),
    .signimmD   (signimmD),
    .rsD        (rsD),
    .rtD        (rtD),
    .rdD        (rdD),
    .forwardaE  (forwardaE),
    .forwardbE  (forwardbE),
    .aluoutM    (aluoutM),
    .resultW    (resultW),
    .aluoutE    (aluoutE),
    .writedataE (writedataE),
    .writeregE  (writeregE),
    .rsE        (rsE),
    .rtE        (rtE),
    .regwriteE  (regwriteE),
    .memtoregE  (memtoregE),
    .memwriteE  (memwriteE),
    .zeroE      (zeroE),
    .overflowE  (overflowE)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of D-stage inputs.
  task automatic applyStimulus(input logic [2:0] alu, input logic src, input logic dst,
                               input logic rw, input logic m2r, input logic mw,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd);
    alucontrolD = alu;
    alusrcD     = src;
    regdstD     = dst;
    regwriteD   = rw;
    memtoregD   = m2r;
    memwriteD   = mw;
    rd1D        = a;
    rd2D        = b;
    signimmD    = imm;
    rsD         = rs;
    rtD         = rt;
    rdD         = rd;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    aluoutM   = 32'h0;
    resultW   = 32'h0;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Power-on reset, then load an OR with every enable set.
    #3 resetn = 1'b1;
    applyStimulus(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000000F, 32'h0, 32'h0, 5'd1, 5'd2, 5'd9);
    stepEdge();
    checkOutput("preload_aluout", aluoutE, 32'h0000000F);
    checkOutput("preload_writereg", {27'd0, writeregE}, 32'd9);

    // Reset asserted mid-cycle clears everything without an edge.
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst_aluout", aluoutE, 32'h0);
    checkOutput("rst_zero", {31'd0, zeroE}, 32'd1);
    checkOutput("rst_regwrite", {31'd0, regwriteE}, 32'd0);
    checkOutput("rst_memwrite", {31'd0, memwriteE}, 32'd0);
    checkOutput("rst_writereg", {27'd0, writeregE}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflowE}, 32'd0);
    resetn = 1'b1;

    // Add with immediate: 5 + (-3) = 2. Nothing visible before the edge.
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'h0, 32'hFFFFFFFD, 5'd1, 5'd2, 5'd0);
    #1;
    checkOutput("addi_before_edge", aluoutE, 32'h0);
    stepEdge();
    checkOutput("addi_aluout", aluoutE, 32'd2);
    checkOutput("addi_zero", {31'd0, zeroE}, 32'd0);
    checkOutput("addi_overflow", {31'd0, overflowE}, 32'd0);

    // Sub as beq compare of equal registers.
    applyStimulus(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'h0, 5'd1, 5'd2, 5'd0);
    stepEdge();
    checkOutput("beq_aluout", aluoutE, 32'h0);
    checkOutput("beq_zero", {31'd0, zeroE}, 32'd1);
    checkOutput("beq_overflow", {31'd0, overflowE}, 32'd0);

    // Sub overflow: 0x7FFFFFFF - (-1) wraps to 0x80000000.
    applyStimulus(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd1, 5'd2, 5'd0);
    stepEdge();
    checkOutput("subovf_aluout", aluoutE, 32'h80000000);
    checkOutput("subovf_overflow", {31'd0, overflowE}, 32'd1);

    // Add overflow: 0x7FFFFFFF + 1.
    applyStimulus(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd1, 5'd2, 5'd0);
    stepEdge();
    checkOutput("addovf_aluout", aluoutE, 32'h80000000);
    checkOutput("addovf_overflow", {31'd0, overflowE}, 32'd1);

    // slt with A forwarded from MEM: -2^31 < 1 even though the subtract overflows.
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1, 32'h0, 5'd1, 5'd2, 5'd0);
    forwardaE = 2'b10;
    aluoutM   = 32'h80000000;
    stepEdge();
    checkOutput("slt_fwdA_aluout", aluoutE, 32'd1);
    checkOutput("slt_fwdA_overflow", {31'd0, overflowE}, 32'd0);

    // Same instruction, B now forwarded from WB: 0x7FFFFFFF < 0x7FFFFFFF is false.
    aluoutM   = 32'h7FFFFFFF;
    forwardbE = 2'b01;
    resultW   = 32'h7FFFFFFF;
    #1;
    checkOutput("slt_fwdB_aluout", aluoutE, 32'd0);
    checkOutput("slt_fwdB_writedata", writedataE, 32'h7FFFFFFF);
    checkOutput("slt_fwdB_zero", {31'd0, zeroE}, 32'd1);
    forwardaE = 2'b00;
    forwardbE = 2'b00;

    // Load an add, then stall for two edges while D inputs change.
    applyStimulus(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd20, 32'h0, 5'd5, 5'd4, 5'd6);
    stepEdge();
    checkOutput("stall_load_aluout", aluoutE, 32'd30);
    applyStimulus(3'b001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd100, 32'd200, 32'h55, 5'd11, 5'd8, 5'd12);
    stallE = 1'b1;
    stepEdge();
    stepEdge();
    checkOutput("stall_aluout", aluoutE, 32'd30);
    checkOutput("stall_regwrite", {31'd0, regwriteE}, 32'd1);
    checkOutput("stall_memwrite", {31'd0, memwriteE}, 32'd0);
    checkOutput("stall_writereg", {27'd0, writeregE}, 32'd4);
    checkOutput("stall_rs", {27'd0, rsE}, 32'd5);

    // Flush wins over stall and produces a bubble.
    flushE = 1'b1;
    stepEdge();
    checkOutput("flush_regwrite", {31'd0, regwriteE}, 32'd0);
    checkOutput("flush_memwrite", {31'd0, memwriteE}, 32'd0);
    checkOutput("flush_aluout", aluoutE, 32'h0);
    checkOutput("flush_zero", {31'd0, zeroE}, 32'd1);
    flushE = 1'b0;
    stallE = 1'b0;

    // R-type OR with store path; forwarding code 11 behaves as register.
    applyStimulus(3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hF0, 32'h0F, 32'hABCD, 5'd2, 5'd3, 5'd7);
    forwardaE = 2'b11;
    forwardbE = 2'b11;
    aluoutM   = 32'hDEAD0000;
    resultW   = 32'h0000BEEF;
    stepEdge();
    checkOutput("rtype_writereg", {27'd0, writeregE}, 32'd7);
    checkOutput("rtype_aluout", aluoutE, 32'hFF);
    checkOutput("rtype_writedata", writedataE, 32'h0F);
    checkOutput("rtype_rs", {27'd0, rsE}, 32'd2);
    checkOutput("rtype_rt", {27'd0, rtE}, 32'd3);
    checkOutput("rtype_memtoreg", {31'd0, memtoregE}, 32'd1);
    forwardaE = 2'b00;
    forwardbE = 2'b00;

    // AND and an unused code (011) which must yield zero.
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'd1, 5'd2, 5'd0);
    stepEdge();
    checkOutput("and_aluout", aluoutE, 32'h0F000F00);
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h1, 32'h0, 5'd1, 5'd2, 5'd0);
    stepEdge();
    checkOutput("unused_aluout", aluoutE, 32'h0);
    checkOutput("unused_overflow", {31'd0, overflowE}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
